// File: rtl/bin_to_bcd8_pkg.sv
// ----------------------------------------------------------------------------
// bin_to_bcd8_pkg
// Shared constants and FSM encoding for the sequential binary-to-BCD
// converter on the seven-segment display path.
//   BIN_W_DEF / DIGITS_DEF : default binary input width and BCD digit count
//   BCD_MAX                : largest value representable in eight BCD digits
//   BCD_SAT                : pattern shown when the input exceeds BCD_MAX
//   state_t                : converter FSM states
// ----------------------------------------------------------------------------
package bin_to_bcd8_pkg;

    localparam int          BIN_W_DEF  = 27;
    localparam int          DIGITS_DEF = 8;
    localparam logic [31:0] BCD_MAX    = 32'd99_999_999;
    localparam logic [31:0] BCD_SAT    = 32'h9999_9999;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bin_to_bcd8_digit_adj.sv
// ----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble corrector for one BCD digit: a digit in 5..9
// gets +3 so that the following left shift carries correctly into the next
// digit. Any other value passes through unchanged.
//   din  : current 4-bit digit
//   dout : corrected digit
// ----------------------------------------------------------------------------
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if ((din >= 4'd5) && (din <= 4'd9)) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd8.sv
// ----------------------------------------------------------------------------
// bin_to_bcd8
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Inputs that do not fit in DIGITS decimal digits saturate to all nines and
// raise ovf.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; bcd/ovf hold the last result
//   SHIFT | adjusting and shifting one binary bit per clock into the
//         | BCD accumulator; result is loaded when the counter hits 0
//
// Ports:
//   clk   : system clock
//   rst   : synchronous reset, active low
//   start : conversion request, accepted only in IDLE
//   bin   : binary value, captured when start is accepted
//   busy  : conversion in progress
//   done  : one-cycle pulse when bcd/ovf update
//   bcd   : packed BCD result, digit 0 in [3:0]
//   ovf   : last result was saturated
// ----------------------------------------------------------------------------
module bin_to_bcd8
    import bin_to_bcd8_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [BIN_W-1:0]   sr, sr_nxt;
    logic [BCD_W-1:0]   acc, acc_nxt;
    logic               flag, flag_nxt;
    logic [BCD_W-1:0]   bcd_nxt;
    logic               ovf_nxt;
    logic               done_nxt;
    logic               busy_nxt;

    logic [BCD_W-1:0]   acc_adj;
    logic [BCD_W-1:0]   acc_shift;
    logic               bin_ovf;

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (acc[4*d +: 4]),
            .dout (acc_adj[4*d +: 4])
        );
    end

    // Carry out of the top digit is dropped; the overflow flag covers it.
    assign acc_shift = {acc_adj[BCD_W-2:0], sr[BIN_W-1]};
    assign bin_ovf   = 64'(bin) > 64'(BCD_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            acc   <= '0;
            flag  <= 1'b0;
            bcd   <= '0;
            ovf   <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sr    <= sr_nxt;
            acc   <= acc_nxt;
            flag  <= flag_nxt;
            bcd   <= bcd_nxt;
            ovf   <= ovf_nxt;
            done  <= done_nxt;
            busy  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_nxt    = sr;
        acc_nxt   = acc;
        flag_nxt  = flag;
        bcd_nxt   = bcd;
        ovf_nxt   = ovf;
        done_nxt  = 1'b0;
        busy_nxt  = busy;

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    sr_nxt    = bin;
                    acc_nxt   = '0;
                    cnt_nxt   = CNT_W'(BIN_W - 1);
                    flag_nxt  = bin_ovf;
                    busy_nxt  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                sr_nxt  = {sr[BIN_W-2:0], 1'b0};
                acc_nxt = acc_shift;
                if (cnt == '0) begin
                    bcd_nxt   = flag ? BCD_W'(BCD_SAT) : acc_shift;
                    ovf_nxt   = flag;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bin_to_bcd8.sv
module tb_bin_to_bcd8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [26:0] bin;
    logic        busy;
    logic        done;
    logic [31:0] bcd;
    logic        ovf;

    int n_cmp;
    int n_bad;

    bin_to_bcd8 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One conversion from IDLE: checks latency, busy length, done width,
    // busy/done exclusivity and the result.
    task automatic run_conv(input string tag, input logic [26:0] v,
                            input logic [31:0] eb, input logic eo);
        int  busy_cnt;
        int  lat;
        int  both;
        bit  got;
        busy_cnt = 0;
        lat      = -1;
        both     = 0;
        got      = 1'b0;
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (busy && done) both++;
            if (done) begin
                got = 1'b1;
                lat = i;
            end else if (busy) begin
                busy_cnt++;
            end
        end
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        chk({tag, "_latency"}, 64'(lat), 64'd27);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd27);
        chk({tag, "_busy_and_done"}, 64'(both), 64'd0);
        chk({tag, "_bcd"}, 64'(bcd), 64'(eb));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, "_bcd_held"}, 64'(bcd), 64'(eb));
    endtask

    initial begin : main
        int          n_done;
        int          t;
        int          t_done[3];
        int          k;
        logic [26:0] b2b_in[3];
        logic [31:0] b2b_exp[3];

        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        start = 1'b0;
        bin   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_bcd",  64'(bcd),  64'd0);
        chk("rst_ovf",  64'(ovf),  64'd0);
        rst = 1'b1;

        run_conv("zero",  27'd0,           32'h0000_0000, 1'b0);
        run_conv("mid",   27'd12_345_678,  32'h1234_5678, 1'b0);
        run_conv("max",   27'd99_999_999,  32'h9999_9999, 1'b0);
        run_conv("sat",   27'd100_000_000, 32'h9999_9999, 1'b1);
        run_conv("sat_top", 27'h7FF_FFFF,  32'h9999_9999, 1'b1);
        run_conv("after_sat", 27'd1,       32'h0000_0001, 1'b0);

        // start re-pulsed mid-conversion must be ignored
        @(negedge clk);
        start = 1'b1;
        bin   = 27'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        bin   = 27'd7;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                chk("ignore_bcd", 64'(bcd), 64'h0000_0005);
            end
        end
        chk("ignore_done_count", 64'(n_done), 64'd1);
        chk("ignore_idle", 64'(busy), 64'd0);

        // back-to-back with start held high
        b2b_in[0]  = 27'd9;  b2b_exp[0] = 32'h0000_0009;
        b2b_in[1]  = 27'd10; b2b_exp[1] = 32'h0000_0010;
        b2b_in[2]  = 27'd99; b2b_exp[2] = 32'h0000_0099;
        @(negedge clk);
        start = 1'b1;
        bin   = b2b_in[0];
        k = 0;
        t = 0;
        while (k < 3 && t < 120) begin
            @(negedge clk);
            t++;
            if (done) begin
                t_done[k] = t;
                chk($sformatf("b2b_bcd%0d", k), 64'(bcd), 64'(b2b_exp[k]));
                k++;
                if (k < 3) bin = b2b_in[k];
                else       start = 1'b0;
            end
        end
        start = 1'b0;
        chk("b2b_done_count", 64'(k), 64'd3);
        if (k == 3) begin
            chk("b2b_gap01", 64'(t_done[1] - t_done[0]), 64'd28);
            chk("b2b_gap12", 64'(t_done[2] - t_done[1]), 64'd28);
        end
        repeat (2) @(negedge clk);

        // reset at cycle 10 of a conversion aborts it
        @(negedge clk);
        start = 1'b1;
        bin   = 27'd87_654_321;
        @(posedge clk);
        #1 start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_bcd",  64'(bcd),  64'd0);
        chk("abort_ovf",  64'(ovf),  64'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", 64'(n_done), 64'd0);
        run_conv("post_rst", 27'd87_654_321, 32'h8765_4321, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
